// File: rtl/mem_stage.sv
// mem_stage: E/M pipeline register, byte/half/word data memory and load extension for the M stage.
module mem_stage #(
  parameter int DM_WORDS = 3072,
  parameter int AW = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_E,
  input  logic [31:0] PC_E,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteReg_E,
  input  logic        RegWrite_E,
  input  logic [1:0]  T_new_E,
  input  logic [31:0] ResultW,
  input  logic        ForwardM,
  output logic [31:0] Instr_M,
  output logic [31:0] PC_M,
  output logic [31:0] ALUOutM,
  output logic [31:0] ReadDataM,
  output logic [4:0]  WriteReg_M,
  output logic        RegWrite_M,
  output logic [1:0]  T_new_M
);
  localparam logic [31:0] LIMIT = 32'(4 * DM_WORDS);
  logic [31:0] r_instr, r_pc, r_alu, r_wd;
  logic [4:0]  r_wreg;
  logic        r_rw;
  logic [1:0]  r_tnew;
  logic [31:0] r_mem [DM_WORDS];
  logic [5:0]  w_op;
  logic        w_sw, w_sh, w_sb, w_lw, w_lh, w_lhu, w_lb, w_lbu, w_store, w_in_range;
  logic [AW-1:0] w_idx;
  logic [31:0] w_word, w_sd, w_merged;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_alu   <= '0;
      r_wd    <= '0;
      r_wreg  <= '0;
      r_rw    <= 1'b0;
      r_tnew  <= '0;
    end else begin
      r_instr <= Instr_E;
      r_pc    <= PC_E;
      r_alu   <= ALUOutE;
      r_wd    <= WriteDataE;
      r_wreg  <= WriteReg_E;
      r_rw    <= RegWrite_E;
      r_tnew  <= (T_new_E == 2'd0) ? 2'd0 : T_new_E - 2'd1;
    end
  end
  assign w_op    = r_instr[31:26];
  assign w_sw    = w_op == 6'b101011;
  assign w_sh    = w_op == 6'b101001;
  assign w_sb    = w_op == 6'b101000;
  assign w_lw    = w_op == 6'b100011;
  assign w_lh    = w_op == 6'b100001;
  assign w_lhu   = w_op == 6'b100101;
  assign w_lb    = w_op == 6'b100000;
  assign w_lbu   = w_op == 6'b100100;
  assign w_store = w_sw | w_sh | w_sb;
  assign w_in_range = r_alu < LIMIT;
  assign w_idx   = r_alu[AW+1:2];
  assign w_word  = w_in_range ? r_mem[w_idx] : '0;
  assign w_sd    = ForwardM ? ResultW : r_wd;
  // Partial stores merge into the current word so untouched lanes survive.
  always_comb begin
    w_merged = w_word;
    if (w_sw) w_merged = w_sd;
    else if (w_sh) w_merged[{r_alu[1], 4'b0} +: 16] = w_sd[15:0];
    else if (w_sb) w_merged[{r_alu[1:0], 3'b0} +: 8] = w_sd[7:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= '0;
    end else if (w_store && w_in_range) begin
      r_mem[w_idx] <= w_merged;
      $display("%d@%h: *%h <= %h", $time, PC_M, {r_alu[31:2], 2'b00}, w_merged);
    end
  end
  assign w_half = r_alu[1] ? w_word[31:16] : w_word[15:0];
  assign w_byte = w_word[{r_alu[1:0], 3'b0} +: 8];
  assign ReadDataM = !w_in_range ? '0 :
                     w_lw  ? w_word :
                     w_lh  ? {{16{w_half[15]}}, w_half} :
                     w_lhu ? {16'b0, w_half} :
                     w_lb  ? {{24{w_byte[7]}}, w_byte} :
                     w_lbu ? {24'b0, w_byte} : '0;
  assign Instr_M    = r_instr;
  assign PC_M       = r_pc;
  assign ALUOutM    = r_alu;
  assign WriteReg_M = r_wreg;
  assign RegWrite_M = r_rw;
  assign T_new_M    = r_tnew;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a byte-addressed memory model.
module tb_mem_stage;
  localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000, LW = 6'b100011,
    LH = 6'b100001, LHU = 6'b100101, LB = 6'b100000, LBU = 6'b100100, NOP = 6'b000000;
  localparam int NBYTES = 4 * 3072;
  logic clk = 0, reset = 0;
  logic [31:0] Instr_E = 0, PC_E = 0, ALUOutE = 0, WriteDataE = 0, ResultW = 0;
  logic [4:0] WriteReg_E = 0;
  logic RegWrite_E = 0, ForwardM = 0;
  logic [1:0] T_new_E = 0;
  logic [31:0] Instr_M, PC_M, ALUOutM, ReadDataM;
  logic [4:0] WriteReg_M;
  logic RegWrite_M;
  logic [1:0] T_new_M;
  int errors = 0, checks = 0;
  logic [7:0] mb [NBYTES];
  logic [5:0] p_op;
  logic [31:0] p_a, p_wd, p_rw;
  logic p_fwd;
  logic [31:0] exp_instr, exp_pc, exp_alu, exp_rd;
  logic [4:0] exp_wreg;
  logic exp_rw;
  logic [1:0] exp_tn;

  mem_stage dut (.clk(clk), .reset(reset), .Instr_E(Instr_E), .PC_E(PC_E), .ALUOutE(ALUOutE),
    .WriteDataE(WriteDataE), .WriteReg_E(WriteReg_E), .RegWrite_E(RegWrite_E), .T_new_E(T_new_E),
    .ResultW(ResultW), .ForwardM(ForwardM), .Instr_M(Instr_M), .PC_M(PC_M), .ALUOutM(ALUOutM),
    .ReadDataM(ReadDataM), .WriteReg_M(WriteReg_M), .RegWrite_M(RegWrite_M), .T_new_M(T_new_M));

  always #5 clk = ~clk;

  function automatic void model_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd);
    if (a >= NBYTES) return;
    if (op == SW) for (int i = 0; i < 4; i++) mb[(a & ~32'd3) + i] = 8'(sd >> (8 * i));
    else if (op == SH) for (int i = 0; i < 2; i++) mb[(a & ~32'd1) + i] = 8'(sd >> (8 * i));
    else if (op == SB) mb[a] = sd[7:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
    logic [31:0] w, h, b;
    if (a >= NBYTES) return 0;
    w = {mb[(a & ~32'd3) + 3], mb[(a & ~32'd3) + 2], mb[(a & ~32'd3) + 1], mb[a & ~32'd3]};
    h = {16'b0, mb[(a & ~32'd1) + 1], mb[a & ~32'd1]};
    b = {24'b0, mb[a]};
    case (op)
      LW: return w;
      LH: return h[15] ? (h | 32'hFFFF0000) : h;
      LHU: return h;
      LB: return b[7] ? (b | 32'hFFFFFF00) : b;
      LBU: return b;
      default: return 0;
    endcase
  endfunction

  // Drives one instruction into E while the previous one completes its M cycle.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic fwd, input logic [31:0] rw, input logic [1:0] tn);
    logic [31:0] ins;
    ins = {op, 26'($urandom)};
    Instr_E = ins; PC_E = $urandom; ALUOutE = a; WriteDataE = wd;
    WriteReg_E = 5'($urandom); RegWrite_E = 1'($urandom); T_new_E = tn;
    ForwardM = p_fwd; ResultW = p_fwd ? p_rw : $urandom;
    model_store(p_op, p_a, p_fwd ? p_rw : p_wd);
    exp_instr = ins; exp_pc = PC_E; exp_alu = a; exp_wreg = WriteReg_E; exp_rw = RegWrite_E;
    exp_tn = (tn == 0) ? 2'd0 : tn - 2'd1;
    @(posedge clk); #1;
    p_op = op; p_a = a; p_wd = wd; p_fwd = fwd; p_rw = rw;
    exp_rd = model_load(op, a);
  endtask

  task automatic test_reset;
    Instr_E = {SW, 26'h3FFFFFF}; PC_E = 32'h1234; ALUOutE = 32'h10; WriteDataE = 32'hFFFFFFFF;
    WriteReg_E = 5'd9; RegWrite_E = 1; T_new_E = 2; ForwardM = 1; ResultW = 32'h55;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NBYTES; i++) mb[i] = 0;
    p_op = NOP; p_a = 0; p_wd = 0; p_fwd = 0; p_rw = 0;
    checks++; if (Instr_M !== 0) begin errors++; $display("FAIL reset_instr got=%h want=0", Instr_M); end
    checks++; if (PC_M !== 0) begin errors++; $display("FAIL reset_pc got=%h want=0", PC_M); end
    checks++; if (ALUOutM !== 0) begin errors++; $display("FAIL reset_alu got=%h want=0", ALUOutM); end
    checks++; if (WriteReg_M !== 0) begin errors++; $display("FAIL reset_wreg got=%h want=0", WriteReg_M); end
    checks++; if (RegWrite_M !== 0) begin errors++; $display("FAIL reset_rw got=%b want=0", RegWrite_M); end
    checks++; if (T_new_M !== 0) begin errors++; $display("FAIL reset_tnew got=%h want=0", T_new_M); end
    checks++; if (ReadDataM !== 0) begin errors++; $display("FAIL reset_rd got=%h want=0", ReadDataM); end
    reset = 0;
    issue(LW, 32'h10, 0, 0, 0, 0);
    checks++; if (ReadDataM !== 0) begin errors++; $display("FAIL reset_lw got=%h want=0", ReadDataM); end
  endtask

  task automatic test_merge;
    issue(SW, 32'h100, 32'h11223344, 0, 0, 0);
    issue(SB, 32'h101, 32'h000000AA, 0, 0, 0);
    issue(SH, 32'h102, 32'h0000BEEF, 0, 0, 0);
    issue(LW, 32'h100, 0, 0, 0, 0);
    checks++; if (ReadDataM !== 32'hBEEFAA44) begin errors++; $display("FAIL merge_lw got=%h want=BEEFAA44", ReadDataM); end
  endtask

  task automatic test_ext;
    logic [5:0] ops [5];
    logic [31:0] adr [5], want [5];
    ops = '{LB, LBU, LH, LHU, LB};
    adr = '{32'h22, 32'h23, 32'h22, 32'h20, 32'h20};
    want = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h00000001};
    issue(SW, 32'h20, 32'h80FF7F01, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], adr[i], 0, 0, 0, 0);
      checks++; if (ReadDataM !== want[i]) begin errors++; $display("FAIL ext_%0d got=%h want=%h", i, ReadDataM, want[i]); end
    end
  endtask

  task automatic test_fwd;
    issue(SW, 32'h40, 32'h1, 1, 32'hCAFEBABE, 0);
    issue(LW, 32'h40, 0, 0, 0, 0);
    checks++; if (ReadDataM !== 32'hCAFEBABE) begin errors++; $display("FAIL fwd_lw got=%h want=CAFEBABE", ReadDataM); end
  endtask

  task automatic test_bounds;
    issue(SW, 32'h3000, 32'hDEADBEEF, 0, 0, 0);
    issue(LW, 32'h3000, 0, 0, 0, 0);
    checks++; if (ReadDataM !== 0) begin errors++; $display("FAIL bounds_oob got=%h want=0", ReadDataM); end
    issue(LW, 32'h0, 0, 0, 0, 0);
    checks++; if (ReadDataM !== 0) begin errors++; $display("FAIL bounds_w0 got=%h want=0", ReadDataM); end
    issue(LW, 32'h100, 0, 0, 0, 0);
    checks++; if (ReadDataM !== 32'hBEEFAA44) begin errors++; $display("FAIL bounds_w100 got=%h want=BEEFAA44", ReadDataM); end
    issue(SW, 32'h2FFC, 32'h0BADF00D, 0, 0, 0);
    issue(LW, 32'h2FFC, 0, 0, 0, 0);
    checks++; if (ReadDataM !== 32'h0BADF00D) begin errors++; $display("FAIL bounds_top got=%h want=0BADF00D", ReadDataM); end
  endtask

  task automatic test_passthru;
    logic [1:0] tw [3];
    tw = '{2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 3; i++) begin
      issue(NOP, $urandom, $urandom, 0, 0, 2'(2 - i));
      checks++; if (T_new_M !== tw[i]) begin errors++; $display("FAIL tnew_%0d got=%0d want=%0d", i, T_new_M, tw[i]); end
      checks++; if (ALUOutM !== exp_alu) begin errors++; $display("FAIL pass_alu got=%h want=%h", ALUOutM, exp_alu); end
      checks++; if (PC_M !== exp_pc) begin errors++; $display("FAIL pass_pc got=%h want=%h", PC_M, exp_pc); end
      checks++; if (WriteReg_M !== exp_wreg || RegWrite_M !== exp_rw) begin
        errors++; $display("FAIL pass_wb got=%h/%b want=%h/%b", WriteReg_M, RegWrite_M, exp_wreg, exp_rw);
      end
    end
  endtask

  task automatic test_random;
    logic [5:0] ops [9];
    logic [31:0] a;
    int r;
    ops = '{SW, SH, SB, LW, LH, LHU, LB, LBU, NOP};
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      a = (r < 8) ? 32'($urandom_range(0, 63)) : (r == 8) ? 32'($urandom_range(NBYTES - 8, NBYTES + 7))
                                                           : ($urandom | 32'h10000000);
      issue(ops[$urandom_range(0, 8)], a, $urandom, 1'($urandom), $urandom, 2'($urandom));
      checks++; if (ReadDataM !== exp_rd) begin errors++; $display("FAIL rand_rd_%0d a=%h got=%h want=%h", n, a, ReadDataM, exp_rd); end
      checks++; if (Instr_M !== exp_instr || T_new_M !== exp_tn) begin
        errors++; $display("FAIL rand_pipe_%0d got=%h/%0d want=%h/%0d", n, Instr_M, T_new_M, exp_instr, exp_tn);
      end
    end
  endtask

  initial begin
    test_reset;
    test_merge;
    test_ext;
    test_fwd;
    test_bounds;
    test_passthru;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the five-stage MIPS pipeline. It is the consumer end of the Execute-stage output bundle.
- It contains the E/M pipeline register, which captures the Execute outputs every cycle.
- It holds the word-addressed data memory and performs byte, half and word stores and loads.
- It feeds the registered ALU result back as the M-stage forwarding source.
- It passes the register-write bundle and the decremented T_new to the M/W register.

Parameters:
- DM_WORDS, 3072, number of 32-bit words in data memory (valid byte range 0x0000 to 4*DM_WORDS-1).
- AW, 12, word-index width; index = address[AW+1:2].

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Instr_E  input  32  instruction in E.
- PC_E  input  32  PC of the instruction in E.
- ALUOutE  input  32  E result: ALU, lui or PC+8 value.
- WriteDataE  input  32  forwarded rt value for stores.
- WriteReg_E  input  5  destination register.
- RegWrite_E  input  1  register-write enable.
- T_new_E  input  2  cycles until the result is ready, counted from E.
- ResultW  input  32  W-stage writeback value (store-data forwarding).
- ForwardM  input  1  1 = replace the store data with ResultW.
- Instr_M  output  32  registered Instr_E.
- PC_M  output  32  registered PC_E.
- ALUOutM  output  32  registered ALUOutE; also the forwarding source for E and D.
- ReadDataM  output  32  extended load data (combinational from the M-stage state).
- WriteReg_M  output  5  registered WriteReg_E.
- RegWrite_M  output  1  registered RegWrite_E.
- T_new_M  output  2  registered (T_new_E==0 ? 0 : T_new_E-1).

Behaviour:
E/M register:
- On every rising edge the register loads the E bundle; there is no stall.
- While reset=1 at an edge, all E/M fields clear to 0. Instr_M=0 decodes as nop.
- After reset the outputs are Instr_M=0, PC_M=0, ALUOutM=0, WriteReg_M=0, RegWrite_M=0 and T_new_M=0. ReadDataM=0 because Instr_M is not a load.
- Latency from E to M outputs: 1 cycle.

Decode (from Instr_M[31:26]):
- Stores: sw=101011, sh=101001, sb=101000.
- Loads: lw=100011, lh=100001, lhu=100101, lb=100000, lbu=100100.
- Any other opcode: no memory access.

Addressing:
- A = ALUOutM; word index = A[AW+1:2].
- In range when A < 4*DM_WORDS; A[31:AW+2] must be zero.

Store data:
- SD = ForwardM ? ResultW : registered WriteDataE.

Stores (synchronous, at the edge ending the M cycle, only if in range and reset=0):
- sw: the whole word becomes SD. A[1:0] is ignored.
- sh: A[1] selects the half (0 = [15:0], 1 = [31:16]). That half becomes SD[15:0]; the other half is unchanged.
- sb: A[1:0] selects the byte lane (0 = [7:0], …, 3 = [31:24]). That lane becomes SD[7:0]; the other bytes are unchanged.
- Out-of-range stores are dropped silently.
- Each performed store emits `$display("%d@%h: *%h <= %h", $time, PC_M, {A[31:2],2'b00}, merged_word)`.

Loads (combinational):
- W = mem[index].
- lw: W.
- lh: sign-extended half selected by A[1]. lhu: zero-extended.
- lb: sign-extended byte selected by A[1:0]. lbu: zero-extended.
- Out-of-range loads and non-loads give ReadDataM=0.

Reset of memory:
- reset=1 clears every memory word to 0 at the edge.
- Reset has priority over a store in the same cycle.

Write-then-read:
- A load in the cycle after a store to the same word sees the merged word.
- There is no internal read-during-write bypass. Only one instruction occupies M at a time.

T_new:
- T_new_M saturates at 0: T_new_E of 2 gives 1, 1 gives 0, 0 gives 0.

Test Plan:
1. Reset: hold reset for 2 cycles with a nonzero E bundle. All M outputs must be 0, and an lw of address 0x10 afterwards must return 0.
2. Byte and half merge:
   - Store sw 0x11223344 to 0x100, then sb 0xAA to 0x101, then sh 0xBEEF to 0x102.
   - A following lw of 0x100 must return 0xBEEFAA44.
   - The three display lines must show merged words 0x11223344, 0x1122AA44 and 0xBEEFAA44 at address 0x00000100.
3. Load extension, with word 0x80FF7F01 at 0x20:
   - lb 0x22 → 0xFFFFFFFF.
   - lbu 0x23 → 0x00000080.
   - lh 0x22 → 0xFFFF80FF.
   - lhu 0x20 → 0x00007F01.
   - lb 0x20 → 0x00000001.
4. Store forwarding: sw with WriteDataE=0x1, ForwardM=1 and ResultW=0xCAFEBABE to 0x40. A following lw of 0x40 must return 0xCAFEBABE.
5. Bounds: sw 0xDEADBEEF to 0x3000. There must be no display line and no change to any word, and lw of 0x3000 must return 0. sw to 0x2FFC must then read back.
6. Pass-through and T_new:
   - Drive T_new_E 2, 1, 0 on successive cycles; T_new_M must be 1, 0, 0 one cycle later.
   - ALUOutM, WriteReg_M, RegWrite_M and PC_M must equal the prior-cycle E values.
